// File: rtl/tt_sweep_ctrl_pkg.sv
// Shared types and widths for the truth-table sweep controller.
package tt_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int ROW_W = 3;
  localparam int TBL_W = 8;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TBL_W - 1);

endpackage

// File: rtl/tt_sweep_ctrl_settle_timer.sv
// Settle-time down-counter: load a count, decrement while enabled, expire at zero.
module settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 8 input rows of a 3-input gate, samples its response after a
// programmable settle time and compares the measured truth table to a golden one.
module tt_sweep_ctrl
  import tt_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [TBL_W-1:0]    expected,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                dut_out,
  output logic [ROW_W-1:0]    dut_in,
  output logic                busy,
  output logic                done,
  output logic [TBL_W-1:0]    captured,
  output logic [TBL_W-1:0]    mismatch,
  output logic                pass
);

  localparam logic [SETTLE_W-1:0] S_ONE = SETTLE_W'(1);

  state_t               state;
  logic [ROW_W-1:0]     row;
  logic [ROW_W-1:0]     bit_idx;
  logic [TBL_W-1:0]     exp_l;
  logic [SETTLE_W-1:0]  s_lat;
  logic [SETTLE_W-1:0]  s_src;
  logic [SETTLE_W-1:0]  load_val;
  logic                 timer_load;
  logic                 timer_count;
  logic                 expire;

  // Row k lives at table bit 7-k, which for a 3-bit row is just ~k.
  assign bit_idx = ~row;

  // The timer counts remaining cycles after the current one, so a row holds
  // for max(S,1) cycles. On the accepting IDLE cycle the live input is used.
  always_comb begin
    s_src       = (state == IDLE) ? settle_cycles : s_lat;
    load_val    = (s_src == '0) ? '0 : (s_src - S_ONE);
    timer_load  = ((state == IDLE) && start) ||
                  ((state == SAMPLE) && !abort && (row != ROW_LAST));
    timer_count = (state == SETTLE);
  end

  settle_timer #(.W(SETTLE_W)) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .count    (timer_count),
    .load_val (load_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      row      <= '0;
      exp_l    <= '0;
      s_lat    <= '0;
      dut_in   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      captured <= '0;
      mismatch <= '0;
      pass     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          dut_in <= '0;
          busy   <= 1'b0;
          if (start) begin
            exp_l    <= expected;
            s_lat    <= settle_cycles;
            captured <= '0;
            mismatch <= '0;
            pass     <= 1'b0;
            row      <= '0;
            busy     <= 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            busy   <= 1'b0;
            dut_in <= '0;
            state  <= IDLE;
          end else if (expire) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            busy   <= 1'b0;
            dut_in <= '0;
            state  <= IDLE;
          end else begin
            captured[bit_idx] <= dut_out;
            mismatch[bit_idx] <= dut_out ^ exp_l[bit_idx];
            if (row == ROW_LAST) begin
              dut_in <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              row    <= row + ROW_W'(1);
              dut_in <= row + ROW_W'(1);
              state  <= SETTLE;
            end
          end
        end
        DONE: begin
          pass  <= (mismatch == '0);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy   <= 1'b0;
          dut_in <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
